tjmono2_rx_filter: RTL and testbench

TJMONO2_RX_FILTER -- requirements
Module: tjmono2_rx_filter

---
 rtl/tjmono2_pkg.sv | 22 ++
 rtl/tjmono2_fwft_buf.sv | 61 ++++++
 rtl/tjmono2_rx_filter.sv | 113 +++++++++++
 tb/tb_tjmono2_rx_filter.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/tjmono2_pkg.sv
// Shared definitions for the tjmono2 receive path: word layout, FSM encoding
// and the empty-record test used by the filter.
package tjmono2_pkg;

  localparam int ID_W      = 4;
  localparam int PAYLOAD_W = 28;
  localparam int WORD_W    = ID_W + PAYLOAD_W;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_READ    = 2'd1,
    ST_CAPTURE = 2'd2
  } rx_state_e;

  // The identifier nibble never takes part in the match, only the payload.
  function automatic logic isEmptyRecord(input logic [WORD_W-1:0]    word,
                                         input logic [PAYLOAD_W-1:0] pattern,
                                         input logic                 enable);
    return enable && (word[PAYLOAD_W-1:0] == pattern);
  endfunction

endpackage

// File: rtl/tjmono2_fwft_buf.sv
// First-word-fall-through buffer of 2**DEPTH_LOG2 words: the head word is
// always presented on o_data and a pop simply advances the read pointer.
module tjmono2_fwft_buf #(
  parameter int DEPTH_LOG2 = 2,
  parameter int WIDTH      = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  i_push,
  input  logic [WIDTH-1:0]      i_data,
  input  logic                  i_pop,
  output logic                  o_empty,
  output logic [WIDTH-1:0]      o_data,
  output logic [DEPTH_LOG2:0]   o_count
);

  localparam int                DEPTH   = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0] LP_FULL = (DEPTH_LOG2 + 1)'(DEPTH);

  logic [WIDTH-1:0]      r_mem [DEPTH];
  logic [DEPTH_LOG2-1:0] r_wrPtr;
  logic [DEPTH_LOG2-1:0] r_rdPtr;
  logic [DEPTH_LOG2:0]   r_count;
  logic                  w_push;
  logic                  w_pop;

  assign w_push = i_push && (r_count != LP_FULL);
  assign w_pop  = i_pop && (r_count != '0);

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wrPtr] <= i_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wrPtr <= '0;
      r_rdPtr <= '0;
      r_count <= '0;
    end else begin
      if (w_push) begin
        r_wrPtr <= r_wrPtr + 1'b1;
      end
      if (w_pop) begin
        r_rdPtr <= r_rdPtr + 1'b1;
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // Storage is not reset, so the head is masked to zero while nothing is held.
  assign o_empty = (r_count == '0);
  assign o_data  = o_empty ? '0 : r_mem[r_rdPtr];
  assign o_count = r_count;

endmodule

// File: rtl/tjmono2_rx_filter.sv
// Pulls words from an upstream rx FIFO, optionally drops empty records, and
// buffers the rest for a FWFT consumer. Define TJMONO2_RX_FILTER_CNT_EN to
// build the dropped-word counter; otherwise DROP_CNT reads as zero.
module tjmono2_rx_filter
  import tjmono2_pkg::*;
#(
  parameter int DEPTH_LOG2 = 2,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  FIFO_CLK,
  input  logic                  FIFO_RST_N,
  input  logic                  IN_EMPTY,
  output logic                  IN_READ,
  input  logic [WORD_W-1:0]     IN_DATA,
  input  logic                  EN_FILTER,
  input  logic [PAYLOAD_W-1:0]  EMPTY_PATTERN,
  input  logic                  OUT_READ,
  output logic                  OUT_EMPTY,
  output logic [WORD_W-1:0]     OUT_DATA,
  input  logic                  CLR_CNT,
  output logic [CNT_WIDTH-1:0]  DROP_CNT
);

  localparam logic [DEPTH_LOG2:0] LP_DEPTH = (DEPTH_LOG2 + 1)'(1 << DEPTH_LOG2);
  localparam logic [DEPTH_LOG2:0] LP_ONE   = (DEPTH_LOG2 + 1)'(1);
  localparam logic [DEPTH_LOG2:0] LP_TWO   = (DEPTH_LOG2 + 1)'(2);

  rx_state_e           r_state;
  rx_state_e           w_nextState;
  logic                w_capture;
  logic                w_drop;
  logic                w_push;
  logic [DEPTH_LOG2:0] w_count;
  logic [DEPTH_LOG2:0] w_free;

  // Free space ignores any pop in the same cycle, so it can only under-estimate.
  assign w_free = LP_DEPTH - w_count;

  always_ff @(posedge FIFO_CLK or negedge FIFO_RST_N) begin
    if (!FIFO_RST_N) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  always_comb begin
    w_nextState = r_state;
    IN_READ     = 1'b0;
    w_capture   = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (!IN_EMPTY && (w_free >= LP_ONE)) begin
          w_nextState = ST_READ;
        end
      end
      ST_READ: begin
        IN_READ     = 1'b1;
        w_nextState = ST_CAPTURE;
      end
      ST_CAPTURE: begin
        w_capture = 1'b1;
        // Back-to-back only if a slot remains beyond the word landing now.
        if (!IN_EMPTY && (w_free >= LP_TWO)) begin
          w_nextState = ST_READ;
        end else begin
          w_nextState = ST_IDLE;
        end
      end
      default: w_nextState = ST_IDLE;
    endcase
  end

  assign w_drop = w_capture && isEmptyRecord(IN_DATA, EMPTY_PATTERN, EN_FILTER);
  assign w_push = w_capture && !w_drop;

  tjmono2_fwft_buf #(
    .DEPTH_LOG2 (DEPTH_LOG2),
    .WIDTH      (WORD_W)
  ) u_buf (
    .clk     (FIFO_CLK),
    .rst_n   (FIFO_RST_N),
    .i_push  (w_push),
    .i_data  (IN_DATA),
    .i_pop   (OUT_READ),
    .o_empty (OUT_EMPTY),
    .o_data  (OUT_DATA),
    .o_count (w_count)
  );

`ifdef TJMONO2_RX_FILTER_CNT_EN
  logic [CNT_WIDTH-1:0] r_dropCnt;

  // Clear beats a same-cycle drop; the count sticks at all-ones.
  always_ff @(posedge FIFO_CLK or negedge FIFO_RST_N) begin
    if (!FIFO_RST_N) begin
      r_dropCnt <= '0;
    end else if (CLR_CNT) begin
      r_dropCnt <= '0;
    end else if (w_drop && (r_dropCnt != '1)) begin
      r_dropCnt <= r_dropCnt + 1'b1;
    end
  end

  assign DROP_CNT = r_dropCnt;
`else
  logic w_unusedClr;

  assign w_unusedClr = CLR_CNT;
  assign DROP_CNT    = '0;
`endif

endmodule

// File: tb/tb_tjmono2_rx_filter.sv
// Directed bench for tjmono2_rx_filter (DEPTH_LOG2=2, CNT_WIDTH=4) driven by a
// small upstream FIFO model; drop-count expectations follow TJMONO2_RX_FILTER_CNT_EN.
module tb_tjmono2_rx_filter;

`ifdef TJMONO2_RX_FILTER_CNT_EN
  localparam bit CNT_EN = 1'b1;
`else
  localparam bit CNT_EN = 1'b0;
`endif

  typedef struct packed {
    logic [31:0] word;
    logic        enFilter;
    logic [27:0] pattern;
    logic        expectOut;
    logic [3:0]  expectCnt;
  } vec_t;

  logic        clk = 1'b0;
  logic        rstN = 1'b0;
  logic        inEmpty;
  logic        inRead;
  logic [31:0] inData = 32'h0;
  logic        enFilter = 1'b0;
  logic [27:0] emptyPattern = 28'h0;
  logic        outRead = 1'b0;
  logic        outEmpty;
  logic [31:0] outData;
  logic        clrCnt = 1'b0;
  logic [3:0]  dropCnt;

  logic [31:0] upMem [0:255];
  int          upWr = 0;
  int          upRd = 0;
  int          readPulses = 0;
  int          checks = 0;
  int          failures = 0;

  vec_t        vecs [8];
  logic [31:0] got [8];
  int          nGot;
  int          base;

  always #5 clk = ~clk;

  tjmono2_rx_filter #(
    .DEPTH_LOG2 (2),
    .CNT_WIDTH  (4)
  ) dut (
    .FIFO_CLK      (clk),
    .FIFO_RST_N    (rstN),
    .IN_EMPTY      (inEmpty),
    .IN_READ       (inRead),
    .IN_DATA       (inData),
    .EN_FILTER     (enFilter),
    .EMPTY_PATTERN (emptyPattern),
    .OUT_READ      (outRead),
    .OUT_EMPTY     (outEmpty),
    .OUT_DATA      (outData),
    .CLR_CNT       (clrCnt),
    .DROP_CNT      (dropCnt)
  );

  // Upstream FIFO model: a read strobe presents the next word one cycle later.
  assign inEmpty = (upWr == upRd);

  always @(posedge clk) begin
    if (inRead) begin
      readPulses <= readPulses + 1;
    end
    if (inRead && (upWr != upRd)) begin
      inData <= upMem[upRd[7:0]];
      upRd   <= upRd + 1;
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%08h, wanted 0x%08h", name, actual, expected);
    end
  endtask

  task automatic offerWord(input logic [31:0] w);
    upMem[upWr[7:0]] = w;
    upWr++;
  endtask

  task automatic applyStimulus(input vec_t v);
    @(negedge clk);
    enFilter     = v.enFilter;
    emptyPattern = v.pattern;
    offerWord(v.word);
    repeat (4) @(negedge clk);
  endtask

  task automatic popWord();
    outRead = 1'b1;
    repeat (2) @(negedge clk);
    outRead = 1'b0;
  endtask

  task automatic waitForRead(input string name);
    bit found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      @(negedge clk);
      if (inRead) found = 1'b1;
    end
    checks++;
    if (!found) begin
      failures++;
      $display("[TB] FAIL %s: got no IN_READ within 20 cycles, wanted one", name);
    end
  endtask

  task automatic doReset();
    @(negedge clk);
    rstN     = 1'b0;
    outRead  = 1'b0;
    clrCnt   = 1'b0;
    enFilter = 1'b0;
    upWr     = upRd;
    repeat (2) @(negedge clk);
    rstN = 1'b1;
    @(negedge clk);
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: got timeout, wanted $finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    vecs[0] = '{32'h1000_0001, 1'b0, 28'h0000000, 1'b1, 4'd0};
    vecs[1] = '{32'h1000_0000, 1'b0, 28'h0000000, 1'b1, 4'd0};
    vecs[2] = '{32'h1000_0000, 1'b1, 28'h0000000, 1'b0, 4'd1};
    vecs[3] = '{32'h1000_0005, 1'b1, 28'h0000000, 1'b1, 4'd1};
    vecs[4] = '{32'hA123_4567, 1'b1, 28'h1234567, 1'b0, 4'd2};
    vecs[5] = '{32'hA123_4568, 1'b1, 28'h1234567, 1'b1, 4'd2};
    vecs[6] = '{32'hFFFF_FFFF, 1'b1, 28'hFFFFFFF, 1'b0, 4'd3};
    vecs[7] = '{32'h5FFF_FFFE, 1'b1, 28'hFFFFFFF, 1'b1, 4'd3};

    // Reset state
    repeat (2) @(negedge clk);
    checkOutput("reset OUT_EMPTY", 32'(outEmpty), 32'd1);
    checkOutput("reset OUT_DATA", outData, 32'h0);
    checkOutput("reset IN_READ", 32'(inRead), 32'd0);
    checkOutput("reset DROP_CNT", 32'(dropCnt), 32'd0);
    rstN = 1'b1;

    // One word per vector, pop it (plus one ignored pop while empty)
    for (int i = 0; i < 8; i++) begin
      applyStimulus(vecs[i]);
      checkOutput($sformatf("vec%0d OUT_EMPTY", i), 32'(outEmpty), 32'(!vecs[i].expectOut));
      if (vecs[i].expectOut) begin
        checkOutput($sformatf("vec%0d OUT_DATA", i), outData, vecs[i].word);
      end
      checkOutput($sformatf("vec%0d DROP_CNT", i), 32'(dropCnt),
                  CNT_EN ? 32'(vecs[i].expectCnt) : 32'd0);
      popWord();
      checkOutput($sformatf("vec%0d empty after pop", i), 32'(outEmpty), 32'd1);
    end

    // Three words streamed with OUT_READ held high
    doReset();
    outRead = 1'b1;
    for (int i = 1; i <= 3; i++) offerWord(32'h1000_0000 + 32'(i));
    nGot = 0;
    repeat (30) begin
      @(negedge clk);
      if (!outEmpty && nGot < 8) begin
        got[nGot] = outData;
        nGot++;
      end
    end
    outRead = 1'b0;
    checkOutput("stream word count", 32'(nGot), 32'd3);
    for (int i = 0; i < 3; i++) begin
      checkOutput($sformatf("stream word%0d", i), got[i], 32'h1000_0001 + 32'(i));
    end
    checkOutput("stream DROP_CNT", 32'(dropCnt), 32'd0);

    // Backpressure: ten words offered, buffer of four, no pops
    base = readPulses;
    for (int i = 0; i < 10; i++) offerWord(32'h5000_0000 + 32'(i));
    repeat (40) @(negedge clk);
    checkOutput("full IN_READ pulses", 32'(readPulses - base), 32'd4);
    checkOutput("full OUT_EMPTY", 32'(outEmpty), 32'd0);
    base = readPulses;
    repeat (20) @(negedge clk);
    checkOutput("full IN_READ idle", 32'(readPulses - base), 32'd0);
    for (int i = 0; i < 4; i++) begin
      checkOutput($sformatf("full pop%0d", i), outData, 32'h5000_0000 + 32'(i));
      outRead = 1'b1;
      @(negedge clk);
    end
    outRead = 1'b0;

    // Saturation of the drop counter, then clear racing a drop
    doReset();
    enFilter     = 1'b1;
    emptyPattern = 28'h0;
    for (int i = 0; i < 20; i++) offerWord(32'(i) << 28);
    repeat (60) @(negedge clk);
    checkOutput("sat DROP_CNT", 32'(dropCnt), CNT_EN ? 32'hF : 32'd0);
    checkOutput("sat OUT_EMPTY", 32'(outEmpty), 32'd1);
    offerWord(32'h4000_0000);
    waitForRead("clr wait READ");
    @(negedge clk);
    clrCnt = 1'b1;
    @(negedge clk);
    clrCnt = 1'b0;
    checkOutput("clr vs drop DROP_CNT", 32'(dropCnt), 32'd0);
    offerWord(32'h4000_0000);
    repeat (5) @(negedge clk);
    checkOutput("count after clr", 32'(dropCnt), CNT_EN ? 32'd1 : 32'd0);

    // Reset asserted while a word is being captured
    @(negedge clk);
    enFilter = 1'b0;
    offerWord(32'h1234_5678);
    waitForRead("rst wait READ");
    @(negedge clk);
    rstN = 1'b0;
    #1;
    checkOutput("rst-capture OUT_EMPTY", 32'(outEmpty), 32'd1);
    checkOutput("rst-capture IN_READ", 32'(inRead), 32'd0);
    checkOutput("rst-capture OUT_DATA", outData, 32'h0);
    repeat (2) @(negedge clk);
    rstN = 1'b1;
    base = readPulses;
    repeat (10) @(negedge clk);
    checkOutput("post-rst OUT_EMPTY", 32'(outEmpty), 32'd1);
    checkOutput("post-rst IN_READ", 32'(readPulses - base), 32'd0);
    offerWord(32'h2000_0002);
    repeat (4) @(negedge clk);
    checkOutput("post-rst word", outData, 32'h2000_0002);
    checkOutput("post-rst not empty", 32'(outEmpty), 32'd0);
    popWord();
    checkOutput("post-rst single word", 32'(outEmpty), 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
